sobol_point_sched: RTL and testbench

Run controller for the Sobol generator lanes. It starts a run of a programmed number of points and enables all dimension generators together. It deserialises each lane's 6-bit LSB-first serial output into words, assembles one word per dimension into a point, and buffers points in a small FIFO behind a valid/ready handshake. It sits between the per-dimension serial generators and the downstream consumer (LFSR comparator / stochastic-number converter).

---
 rtl/sobol_point_sched.sv | 224 ++++++++++++++++++++++
 tb/tb_sobol_point_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sobol_point_sched.sv
// sobol_point_sched
// Run controller for the Sobol generator lanes. A run produces num_pts points.
// While a run is active, every dimension lane is enabled together. Each lane
// shifts in W-bit words LSB first. Once every lane holds a finished word, the
// words are packed into one point and pushed into a small FIFO. The consumer
// drains that FIFO through a valid/ready handshake.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start, num_pts    start a run of num_pts points (IDLE only, num_pts != 0)
//   abort             end the active run at once and flush the FIFO
//   gen_en            enable to all generator lanes
//   gen_bit, gen_vld  serial bit and bit-valid from each lane
//   pt_data           FIFO head; lane d occupies bits [d*W +: W]
//   pt_valid          FIFO non-empty
//   pt_ready          consumer accepts the head
//   busy              run active (RUN or DRAIN)
//   done              one-cycle pulse when a run ends or is aborted
//   ovf               sticky: a completed point was dropped on a full FIFO
//   err               sticky: lane framing error
//
// Handshake: the head moves to the consumer on every rising edge where
// pt_valid && pt_ready. pt_data is stable while pt_valid is high and no
// transfer has taken place.
module sobol_point_sched #(
  parameter int DIMS   = 2,
  parameter int W      = 6,
  parameter int NPTS_W = 6,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [NPTS_W-1:0]   num_pts,
  output logic                gen_en,
  input  logic [DIMS-1:0]     gen_bit,
  input  logic [DIMS-1:0]     gen_vld,
  output logic [DIMS*W-1:0]   pt_data,
  output logic                pt_valid,
  input  logic                pt_ready,
  output logic                busy,
  output logic                done,
  output logic                ovf,
  output logic                err
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                       state_q, state_d;
  logic [NPTS_W-1:0]            num_q, num_d;
  logic [NPTS_W-1:0]            cnt_q, cnt_d;
  logic [DIMS-1:0][BW-1:0]      bitcnt_q, bitcnt_d;
  logic [DIMS-1:0][W-1:0]       shift_q, shift_d;
  logic [DIMS-1:0][W-1:0]       word_q, word_d;
  logic [DIMS-1:0]              wflag_q, wflag_d;
  logic [DEPTH-1:0][DIMS*W-1:0] mem_q, mem_d;
  logic [AW-1:0]                wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]                count_q, count_d;
  logic [DIMS*W-1:0]            head_q, head_d;
  logic                         gen_en_q, gen_en_d;
  logic                         valid_q, valid_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         ovf_q, ovf_d;
  logic                         err_q, err_d;

  logic [DIMS-1:0]              lane_cmp;
  logic                         pop, push;
  logic [DIMS*W-1:0]            point_data;

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    cnt_d      = cnt_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    word_d     = word_q;
    wflag_d    = wflag_q;
    mem_d      = mem_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
    done_d     = 1'b0;
    lane_cmp   = '0;
    push       = 1'b0;
    point_data = '0;
    pop        = valid_q && pt_ready;

    unique case (state_q)
      S_IDLE: begin
        if (start && (num_pts != '0)) begin
          state_d  = S_RUN;
          num_d    = num_pts;
          cnt_d    = '0;
          bitcnt_d = '0;
          wflag_d  = '0;
          ovf_d    = 1'b0;
          err_d    = 1'b0;
        end
      end
      S_RUN: begin
        for (int d = 0; d < DIMS; d++) begin
          if (gen_vld[d]) begin
            shift_d[d][bitcnt_q[d]] = gen_bit[d];
            if (bitcnt_q[d] == LAST_BIT) begin
              // A finished word goes into its own holding register. The lane
              // can then start its next word before the other lanes finish.
              lane_cmp[d] = 1'b1;
              bitcnt_d[d] = '0;
              word_d[d]   = shift_d[d];
              if (wflag_q[d]) err_d = 1'b1;
              wflag_d[d]  = 1'b1;
            end else begin
              bitcnt_d[d] = bitcnt_q[d] + 1'b1;
            end
          end else if (bitcnt_q[d] != '0) begin
            // The burst ended partway through a word, so discard the partial word.
            err_d       = 1'b1;
            bitcnt_d[d] = '0;
          end
        end
        if (&(wflag_q | lane_cmp)) begin
          point_data = word_d;
          wflag_d    = '0;
          cnt_d      = cnt_q + 1'b1;
          if ((count_q != FULL_CNT) || pop) push = 1'b1;
          else                              ovf_d = 1'b1;
          if (cnt_d == num_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: ;
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      mem_d[wr_q] = point_data;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

    if ((state_q == S_DRAIN) && (count_d == '0)) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
    end

    // An abort wins over a point push and over start in the same cycle.
    if (abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      done_d   = 1'b1;
      count_d  = '0;
      wr_d     = '0;
      rd_d     = '0;
      bitcnt_d = '0;
      wflag_d  = '0;
      ovf_d    = ovf_q;
      err_d    = err_q;
    end

    gen_en_d = (state_d == S_RUN);
    busy_d   = (state_d != S_IDLE);
    valid_d  = (count_d != '0);
    head_d   = mem_d[rd_d];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      num_q    <= '0;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      word_q   <= '0;
      wflag_q  <= '0;
      mem_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      head_q   <= '0;
      gen_en_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      word_q   <= word_d;
      wflag_q  <= wflag_d;
      mem_q    <= mem_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
      head_q   <= head_d;
      gen_en_q <= gen_en_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign gen_en   = gen_en_q;
  assign pt_data  = head_q;
  assign pt_valid = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ovf      = ovf_q;
  assign err      = err_q;

endmodule

// File: tb/tb_sobol_point_sched.sv
// Testbench for sobol_point_sched (DIMS=2, W=6, NPTS_W=6, DEPTH=4).
// A transaction-level model keeps the run phase, per-lane word assembly and an
// expected-point queue that stands in for the FIFO. The outputs are compared
// against that model after every clock edge.
module tb_sobol_point_sched;
  localparam int W     = 6;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, start, abort, pt_ready;
  logic [5:0]  num_pts;
  logic [1:0]  gen_bit, gen_vld;
  logic        gen_en, pt_valid, busy, done, ovf, err;
  logic [11:0] pt_data;

  sobol_point_sched #(.DIMS(2), .W(6), .NPTS_W(6), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_pts(num_pts),
    .gen_en(gen_en), .gen_bit(gen_bit), .gen_vld(gen_vld),
    .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .busy(busy), .done(done), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  int          checks = 0;
  int          errors = 0;
  logic [11:0] exp_q[$];
  int          phase;            // 0 idle, 1 run, 2 drain
  int          m_num, m_cnt;
  bit          exp_ovf, exp_err, exp_done;
  logic [5:0]  part[2];
  logic [5:0]  slot[2];
  int          nb[2];
  bit          has[2];
  int          done_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic lanes_clear();
    for (int d = 0; d < 2; d++) begin
      part[d] = '0; slot[d] = '0; nb[d] = 0; has[d] = 1'b0;
    end
  endtask

  task automatic model_reset();
    phase = 0; exp_q.delete(); exp_ovf = 0; exp_err = 0; exp_done = 0;
    lanes_clear();
  endtask

  task automatic check_outputs();
    chk("busy",     busy,     phase != 0);
    chk("gen_en",   gen_en,   phase == 1);
    chk("done",     done,     exp_done);
    chk("pt_valid", pt_valid, exp_q.size() != 0);
    chk("ovf",      ovf,      exp_ovf);
    chk("err",      err,      exp_err);
    if (exp_q.size() != 0) chk("pt_data", pt_data, exp_q[0]);
  endtask

  // One clock edge: capture inputs, advance the model, compare outputs.
  task automatic tick();
    logic       s, a, pop;
    logic [5:0] n;
    logic [1:0] v, b;
    int         prev;
    s = start; a = abort; n = num_pts; v = gen_vld; b = gen_bit;
    pop = (exp_q.size() != 0) && pt_ready;
    @(posedge clk); #1;
    if (done === 1'b1) done_seen++;
    if (!rst) begin
      model_reset();
      check_outputs();
      return;
    end
    prev = phase; exp_done = 0;
    if (a && prev != 0) begin
      phase = 0; exp_q.delete(); lanes_clear(); exp_done = 1;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (prev == 0) begin
        if (s && n != 0) begin
          phase = 1; m_num = n; m_cnt = 0; lanes_clear(); exp_ovf = 0; exp_err = 0;
        end
      end else if (prev == 1) begin
        for (int d = 0; d < 2; d++) begin
          if (v[d]) begin
            if (nb[d] == 0) part[d] = '0;
            part[d] = part[d] | (6'(b[d]) << nb[d]);
            nb[d]++;
            if (nb[d] == W) begin
              if (has[d]) exp_err = 1;
              slot[d] = part[d]; has[d] = 1; nb[d] = 0;
            end
          end else if (nb[d] != 0) begin
            exp_err = 1; nb[d] = 0;
          end
        end
        if (has[0] && has[1]) begin
          has[0] = 0; has[1] = 0; m_cnt++;
          if (exp_q.size() < DEPTH) exp_q.push_back({slot[1], slot[0]});
          else                      exp_ovf = 1;
          if (m_cnt == m_num) phase = 2;
        end
      end else if (prev == 2 && exp_q.size() == 0) begin
        phase = 0; exp_done = 1;
      end
    end
    check_outputs();
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_run(input logic [5:0] n);
    num_pts = n; start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_pair(input logic [5:0] w0, input logic [5:0] w1, input bit rnd_ready);
    for (int i = 0; i < 6; i++) begin
      gen_vld = 2'b11; gen_bit = {w1[i], w0[i]};
      if (rnd_ready) pt_ready = 1'($urandom_range(0, 1));
      tick();
    end
    gen_vld = 2'b00; gen_bit = 2'b00; tick();
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy === 1'b1 && k < budget) begin tick(); k++; end
    chk("idle_reached", busy, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [5:0] wa, wb, wc;
    int n;
    rst = 1'b0; start = 0; abort = 0; pt_ready = 0; num_pts = 0;
    gen_bit = 0; gen_vld = 0; done_seen = 0;
    model_reset();

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("rst_pt_data", pt_data, 12'h000);
    rst = 1'b1;
    tick(); tick();

    // Basic run: three points of 0x15 / 0x2A with pt_ready held high
    pt_ready = 1'b1; done_seen = 0;
    start_run(6'd3);
    repeat (3) send_pair(6'h15, 6'h2A, 0);
    wait_idle(20);
    tick();
    chk("done_pulses", done_seen, 1);

    // Stalled consumer: 4 points buffered, 2 dropped, then drained
    pt_ready = 1'b0;
    start_run(6'd6);
    repeat (6) send_pair(6'h15, 6'h2A, 0);
    chk("ovf_after_drop", ovf, 1'b1);
    repeat (3) tick();
    chk("busy_while_full", busy, 1'b1);
    pt_ready = 1'b1;
    wait_idle(20);

    // Lane 1 breaks after 3 bits; its next full word pairs with lane 0
    wa = 6'($urandom_range(0, 63)); wb = 6'($urandom_range(0, 63));
    start_run(6'd2);
    for (int i = 0; i < 6; i++) begin
      gen_vld = (i < 3) ? 2'b11 : 2'b01; gen_bit = {1'b1, wa[i]}; tick();
    end
    chk("err_framing", err, 1'b1);
    for (int i = 0; i < 6; i++) begin
      gen_vld = 2'b10; gen_bit = {wb[i], 1'b0}; tick();
    end
    gen_vld = 0; gen_bit = 0; tick();
    send_pair(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 0);
    wait_idle(20);

    // Lane 0 finishes twice before lane 1: the second word replaces the first
    wa = 6'($urandom_range(0, 63)); wb = 6'($urandom_range(0, 63));
    wc = 6'($urandom_range(0, 63));
    start_run(6'd1);
    for (int i = 0; i < 6; i++) begin gen_vld = 2'b01; gen_bit = {1'b0, wa[i]}; tick(); end
    gen_vld = 0; tick();
    for (int i = 0; i < 6; i++) begin gen_vld = 2'b01; gen_bit = {1'b0, wb[i]}; tick(); end
    gen_vld = 0; tick();
    for (int i = 0; i < 6; i++) begin gen_vld = 2'b10; gen_bit = {wc[i], 1'b0}; tick(); end
    gen_vld = 0; gen_bit = 0; tick();
    wait_idle(20);

    // Abort coincident with a point completion, 2 entries queued
    pt_ready = 1'b0;
    start_run(6'd5);
    repeat (2) send_pair(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 0);
    wa = 6'($urandom_range(0, 63));
    for (int i = 0; i < 6; i++) begin
      gen_vld = 2'b11; gen_bit = {wa[i], wa[i]};
      if (i == 5) abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    chk("abort_valid", pt_valid, 1'b0);
    gen_vld = 0; gen_bit = 0; tick();
    pt_ready = 1'b1;

    // start with num_pts == 0 is ignored; start and num_pts changes mid-run ignored
    start_run(6'd0);
    repeat (2) tick();
    start_run(6'd2);
    num_pts = 6'd9; start = 1'b1; tick(); start = 1'b0;
    repeat (2) send_pair(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 0);
    wait_idle(20);
    chk("latched_num", busy, 1'b0);

    // Reset in the middle of a run, with a 3-bit partial word in flight
    start_run(6'd3);
    send_pair(6'h0F, 6'h30, 0);
    for (int i = 0; i < 3; i++) begin gen_vld = 2'b11; gen_bit = 2'b10; tick(); end
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("midrst_pt_data", pt_data, 12'h000);
    gen_vld = 0; gen_bit = 0;
    tick();
    rst = 1'b1;
    start_run(6'd1);
    send_pair(6'h2C, 6'h13, 0);
    wait_idle(20);

    // Randomized runs with a randomly stalling consumer
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(3, 8);
      start_run(6'(n));
      for (int p = 0; p < n; p++)
        send_pair(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1);
      pt_ready = 1'b1;
      wait_idle(40);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
